prog_counter: RTL and testbench

//  Parametrised, runtime-programmable modulo counter for symbol/sample timing in the BPSK chain.

---
 rtl/prog_counter.sv | 188 ++++++++++++++++++
 tb/tb_prog_counter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/prog_counter.sv
// prog_counter: runtime-programmable up/down modulo counter for BPSK symbol and
// sample timing. Shadowed terminal value, load, clear, one-shot mode, and a
// registered carry pulse on every wrap.
// Optional feature macro: PROG_COUNTER_PRESCALE_EN. When it is defined, a step
// happens once every PRESCALE enabled RUN cycles. When it is not defined, every
// enabled RUN cycle is a step.
module prog_counter #(
    parameter int WIDTH    = 11,
    parameter int TERM_RST = 2047,
    parameter int PRESCALE = 4
) (
    input  logic             clk_sig,
    input  logic             reset_sig,
    input  logic             en_sig,
    input  logic             dir_sig,
    input  logic             clr_sig,
    input  logic             load_sig,
    input  logic [WIDTH-1:0] load_val,
    input  logic             term_wr_sig,
    input  logic [WIDTH-1:0] term_val,
    input  logic             oneshot_sig,
    output logic [WIDTH-1:0] counter_sig,
    output logic [WIDTH-1:0] term_sig,
    output logic             carry_sig,
    output logic             done_sig
);

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_HOLD = 1'b1} state_t;

    state_t           state_r, state_nxt_s;
    logic [WIDTH-1:0] count_r, count_nxt_s;
    logic [WIDTH-1:0] term_r, term_nxt_s;
    logic [WIDTH-1:0] pend_r, pend_nxt_s;
    logic             pend_valid_r, pend_valid_nxt_s;
    logic             carry_r;
    logic             wrap_s;
    logic             tick_s;
    logic             done_s;

`ifdef PROG_COUNTER_PRESCALE_EN
    localparam int PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PRESCALE - 1);

    logic [PRESC_W-1:0] presc_r, presc_nxt_s;

    // Prescaler: counts enabled RUN cycles and restarts on clr, load or en drop.
    always_comb begin
        presc_nxt_s = presc_r;
        tick_s      = 1'b0;
        if (clr_sig || load_sig || !en_sig) begin
            presc_nxt_s = '0;
        end else if (state_r == ST_RUN) begin
            if (presc_r == PRESC_MAX) begin
                tick_s      = 1'b1;
                presc_nxt_s = '0;
            end else begin
                presc_nxt_s = presc_r + PRESC_W'(1);
            end
        end else begin
            presc_nxt_s = presc_r;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk_sig or negedge reset_sig) begin
        if (!reset_sig) begin
            presc_r <= '0;
        end else begin
            presc_r <= presc_nxt_s;
        end
    end
`else
    // Without the prescaler every enabled RUN cycle is a step (PRESCALE is always >= 1).
    always_comb begin
        tick_s = (PRESCALE >= 1) ? 1'b1 : 1'b0;
    end
`endif

    // Count datapath: clear beats load beats step. A wrap or clear promotes the pending terminal.
    always_comb begin
        count_nxt_s = count_r;
        term_nxt_s  = term_r;
        wrap_s      = 1'b0;
        if (clr_sig) begin
            count_nxt_s = '0;
            if (pend_valid_r) begin
                term_nxt_s = pend_r;
            end else begin
                term_nxt_s = term_r;
            end
        end else if (load_sig) begin
            count_nxt_s = (load_val > term_r) ? term_r : load_val;
        end else if ((state_r == ST_RUN) && en_sig && tick_s) begin
            if (!dir_sig) begin
                if (count_r == term_r) begin
                    count_nxt_s = '0;
                    wrap_s      = 1'b1;
                    term_nxt_s  = pend_valid_r ? pend_r : term_r;
                end else begin
                    count_nxt_s = count_r + WIDTH'(1);
                end
            end else begin
                if (count_r == '0) begin
                    wrap_s      = 1'b1;
                    term_nxt_s  = pend_valid_r ? pend_r : term_r;
                    count_nxt_s = pend_valid_r ? pend_r : term_r;
                end else begin
                    count_nxt_s = count_r - WIDTH'(1);
                end
            end
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Pending terminal: a write always lands; a consuming wrap/clear only drops the valid flag.
    always_comb begin
        pend_nxt_s       = pend_r;
        pend_valid_nxt_s = pend_valid_r;
        if (term_wr_sig) begin
            pend_nxt_s       = term_val;
            pend_valid_nxt_s = 1'b1;
        end else if (clr_sig || wrap_s) begin
            pend_valid_nxt_s = 1'b0;
        end else begin
            pend_valid_nxt_s = pend_valid_r;
        end
    end

    // FSM next state: a one-shot wrap parks in HOLD; only clr or load resume counting.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (clr_sig || load_sig) begin
                    state_nxt_s = ST_RUN;
                end else if (wrap_s && oneshot_sig) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_HOLD: begin
                if (clr_sig || load_sig) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: state_nxt_s = ST_RUN;
        endcase
    end

    // FSM outputs: done is a direct decode of the state register.
    always_comb begin
        done_s = 1'b0;
        case (state_r)
            ST_HOLD: done_s = 1'b1;
            ST_RUN:  done_s = 1'b0;
            default: done_s = 1'b0;
        endcase
    end

    // State, count, terminal and carry registers.
    always_ff @(posedge clk_sig or negedge reset_sig) begin
        if (!reset_sig) begin
            state_r      <= ST_RUN;
            count_r      <= '0;
            term_r       <= WIDTH'(TERM_RST);
            pend_r       <= WIDTH'(TERM_RST);
            pend_valid_r <= 1'b0;
            carry_r      <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            count_r      <= count_nxt_s;
            term_r       <= term_nxt_s;
            pend_r       <= pend_nxt_s;
            pend_valid_r <= pend_valid_nxt_s;
            carry_r      <= wrap_s;
        end
    end

    assign counter_sig = count_r;
    assign term_sig    = term_r;
    assign carry_sig   = carry_r;
    assign done_sig    = done_s;

endmodule

// File: tb/tb_prog_counter.sv
// Self-checking bench for prog_counter: directed scenarios plus a randomized
// phase, all compared edge by edge against a behavioural model of the counter.
module tb_prog_counter;

    localparam int W        = 11;
    localparam int TERM_RST = 2047;
    localparam int PRESCALE = 4;

    logic         clk_sig = 1'b0;
    logic         reset_sig;
    logic         en_sig, dir_sig, clr_sig, load_sig, term_wr_sig, oneshot_sig;
    logic [W-1:0] load_val, term_val;
    logic [W-1:0] counter_sig, term_sig;
    logic         carry_sig, done_sig;

    int passed = 0;
    int total  = 0;

    // Behavioural model state.
    int m_cnt, m_term, m_pend, m_presc;
    bit m_pv, m_hold, m_carry;

    prog_counter #(.WIDTH(W), .TERM_RST(TERM_RST), .PRESCALE(PRESCALE)) dut (
        .clk_sig     (clk_sig),
        .reset_sig   (reset_sig),
        .en_sig      (en_sig),
        .dir_sig     (dir_sig),
        .clr_sig     (clr_sig),
        .load_sig    (load_sig),
        .load_val    (load_val),
        .term_wr_sig (term_wr_sig),
        .term_val    (term_val),
        .oneshot_sig (oneshot_sig),
        .counter_sig (counter_sig),
        .term_sig    (term_sig),
        .carry_sig   (carry_sig),
        .done_sig    (done_sig)
    );

    always #5 clk_sig = ~clk_sig;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_term = TERM_RST; m_pend = TERM_RST; m_pv = 1'b0;
        m_hold = 1'b0; m_carry = 1'b0; m_presc = 0;
    endtask

    // One clock edge of the counter, computed from the behavioural rules.
    task automatic model_edge();
        bit step, wrap;
        int old_pend;
        bit old_pv;
        old_pend = m_pend;
        old_pv   = m_pv;
        wrap     = 1'b0;
        step     = 1'b0;
`ifdef PROG_COUNTER_PRESCALE_EN
        if (clr_sig || load_sig || !en_sig) m_presc = 0;
        else if (!m_hold) begin
            if (m_presc == PRESCALE - 1) begin step = 1'b1; m_presc = 0; end
            else m_presc = m_presc + 1;
        end
`else
        step = 1'b1;
`endif
        if (clr_sig) begin
            m_cnt = 0;
            if (old_pv) begin m_term = old_pend; m_pv = 1'b0; end
            m_hold = 1'b0;
        end else if (load_sig) begin
            m_cnt  = (int'(load_val) < m_term) ? int'(load_val) : m_term;
            m_hold = 1'b0;
        end else if (!m_hold && en_sig && step) begin
            if (!dir_sig) begin
                if (m_cnt == m_term) wrap = 1'b1;
                else m_cnt = m_cnt + 1;
            end else begin
                if (m_cnt == 0) wrap = 1'b1;
                else m_cnt = m_cnt - 1;
            end
            if (wrap) begin
                if (old_pv) begin m_term = old_pend; m_pv = 1'b0; end
                m_cnt = dir_sig ? m_term : 0;
                if (oneshot_sig) m_hold = 1'b1;
            end
        end
        m_carry = wrap;
        if (term_wr_sig) begin m_pend = int'(term_val); m_pv = 1'b1; end
    endtask

    task automatic cyc(input string tag);
        @(posedge clk_sig);
        model_edge();
        #1;
        check({tag, ".cnt"},   counter_sig, m_cnt);
        check({tag, ".term"},  term_sig,    m_term);
        check({tag, ".carry"}, carry_sig,   m_carry);
        check({tag, ".done"},  done_sig,    m_hold);
    endtask

    task automatic idle_inputs();
        clr_sig = 1'b0; load_sig = 1'b0; term_wr_sig = 1'b0;
    endtask

    // Program a new terminal and make it active with a clear.
    task automatic set_term(input int t);
        idle_inputs();
        term_wr_sig = 1'b1; term_val = W'(t);
        cyc("set_term_wr");
        term_wr_sig = 1'b0; clr_sig = 1'b1;
        cyc("set_term_clr");
        clr_sig = 1'b0;
    endtask

    initial begin
        int carries;
        reset_sig = 1'b0;
        en_sig = 1'b0; dir_sig = 1'b0; clr_sig = 1'b0; load_sig = 1'b0;
        term_wr_sig = 1'b0; oneshot_sig = 1'b0; load_val = '0; term_val = '0;
        model_reset();
        #12;
        check("rst.cnt",   counter_sig, 0);
        check("rst.term",  term_sig,    TERM_RST);
        check("rst.carry", carry_sig,   0);
        check("rst.done",  done_sig,    0);
        @(posedge clk_sig); #1;
        reset_sig = 1'b1;

        // Full modulus-2048 up count from reset.
        en_sig = 1'b1;
        carries = 0;
        for (int i = 0; i < 2048; i++) begin
            cyc("t1");
            if (carry_sig) carries++;
        end
`ifndef PROG_COUNTER_PRESCALE_EN
        check("t1.final_cnt",   counter_sig, 0);
        check("t1.final_carry", carry_sig,   1);
        check("t1.carry_count", carries,     1);
`endif

        // Down count from 5 with terminal 9, then clamped load.
        set_term(9);
        dir_sig = 1'b1; load_sig = 1'b1; load_val = W'(5);
        cyc("t2_load");
        load_sig = 1'b0;
        for (int i = 0; i < 8; i++) cyc("t2_down");
`ifndef PROG_COUNTER_PRESCALE_EN
        check("t2.after_wrap", counter_sig, 7);
`endif
        load_sig = 1'b1; load_val = W'(12);
        cyc("t2_clamp");
        load_sig = 1'b0;
        check("t2.clamp", counter_sig, 9);

        // Shadowed terminal written mid-count at 100 with terminal 2047.
        set_term(2047);
        dir_sig = 1'b0; load_sig = 1'b1; load_val = W'(100);
        cyc("t3_load");
        load_sig = 1'b0; term_wr_sig = 1'b1; term_val = W'(3);
        cyc("t3_wr");
        term_wr_sig = 1'b0;
        for (int i = 0; i < 1960; i++) cyc("t3_run");
`ifndef PROG_COUNTER_PRESCALE_EN
        check("t3.new_term", term_sig, 3);
`endif

        // One-shot with terminal 7, then resume by load.
        set_term(7);
        oneshot_sig = 1'b1;
        for (int i = 0; i < 12; i++) cyc("t4_os");
`ifndef PROG_COUNTER_PRESCALE_EN
        check("t4.hold_cnt",  counter_sig, 0);
        check("t4.hold_done", done_sig,    1);
`endif
        load_sig = 1'b1; load_val = W'(2);
        cyc("t4_load");
        load_sig = 1'b0;
        check("t4.resume_done", done_sig,    0);
        check("t4.resume_cnt",  counter_sig, 2);
        oneshot_sig = 1'b0;
        cyc("t4_run");

        // Clear and load on the same edge, then async reset mid-count.
        for (int i = 0; i < 3; i++) cyc("t5_pre");
        clr_sig = 1'b1; load_sig = 1'b1; load_val = W'(4);
        cyc("t5_clrload");
        check("t5.clr_wins", counter_sig, 0);
        idle_inputs();
        for (int i = 0; i < 3; i++) cyc("t5_run");
        #2 reset_sig = 1'b0;
        #1;
        model_reset();
        check("t5.arst_cnt",   counter_sig, 0);
        check("t5.arst_term",  term_sig,    TERM_RST);
        check("t5.arst_carry", carry_sig,   0);
        check("t5.arst_done",  done_sig,    0);
        @(posedge clk_sig); #1;
        reset_sig = 1'b1;

        // Randomized mix of all controls with small terminals.
        set_term(5);
        for (int i = 0; i < 1500; i++) begin
            en_sig      = ($urandom_range(0, 7) != 0);
            dir_sig     = $urandom_range(0, 1);
            clr_sig     = ($urandom_range(0, 63) == 0);
            load_sig    = ($urandom_range(0, 31) == 0);
            load_val    = W'($urandom_range(0, 15));
            term_wr_sig = ($urandom_range(0, 15) == 0);
            term_val    = W'($urandom_range(0, 12));
            oneshot_sig = ($urandom_range(0, 7) == 0);
            cyc("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
